// File: rtl/sram_line_port_ctrl.sv
// sram_line_port_ctrl: valid/ready front-end for the single-port line SRAM.
// It tracks fixed-latency reads and buffers returned lines in a credit-gated FIFO.
module sram_line_port_ctrl #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDRESS_WIDTH = 7,
  parameter int READ_LATENCY  = 2,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [DATA_WIDTH-1:0]    i_req_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_data,
  output logic                     o_busy,
  output logic [ADDRESS_WIDTH-1:0] o_sram_address,
  output logic [DATA_WIDTH-1:0]    o_sram_write_data,
  output logic                     o_sram_write_enable,
  input  logic [DATA_WIDTH-1:0]    i_sram_read_data
);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = $clog2(RSP_DEPTH + READ_LATENCY + 1);
  logic [READ_LATENCY-1:0] pipe;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    ready_en;
  logic [DATA_WIDTH-1:0]   mem [RSP_DEPTH];
  logic [OW-1:0]           occ;
  logic                    accept, rd_accept, push, pop;
  // Reads in flight already own a FIFO slot, so credit counts them too.
  always_comb begin
    occ = OW'(count);
    for (int i = 0; i < READ_LATENCY; i++) occ = occ + OW'(pipe[i]);
  end
  assign o_req_ready         = ready_en && (occ < OW'(RSP_DEPTH));
  assign accept              = i_req_valid && o_req_ready;
  assign rd_accept           = accept && !i_req_write;
  assign push                = pipe[READ_LATENCY-1];
  assign pop                 = o_rsp_valid && i_rsp_ready;
  assign o_rsp_valid         = count != '0;
  assign o_rsp_data          = mem[rd_ptr];
  assign o_busy              = (|pipe) || (count != '0);
  assign o_sram_address      = i_req_address;
  assign o_sram_write_data   = i_req_data;
  assign o_sram_write_enable = accept && i_req_write;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      pipe     <= READ_LATENCY'({pipe, rd_accept});
      count    <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_sram_read_data;
  end
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && count == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_sram_line_port_ctrl.sv
// tb_sram_line_port_ctrl: randomized scoreboard bench with a behavioural SRAM and line-memory model.
module tb_sram_line_port_ctrl;
  localparam int DW = 128, AW = 7, RL = 2, DEPTH = 4;
  logic          i_clk = 0, i_rst_n = 0;
  logic          i_req_valid = 0, i_req_write = 0, i_rsp_ready = 1;
  logic [AW-1:0] i_req_address = '0;
  logic [DW-1:0] i_req_data = '0;
  logic          o_req_ready, o_rsp_valid, o_busy, o_sram_write_enable;
  logic [DW-1:0] o_rsp_data, o_sram_write_data, i_sram_read_data;
  logic [AW-1:0] o_sram_address;
  sram_line_port_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL), .RSP_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_address(i_req_address), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data), .o_busy(o_busy),
    .o_sram_address(o_sram_address), .o_sram_write_data(o_sram_write_data),
    .o_sram_write_enable(o_sram_write_enable), .i_sram_read_data(i_sram_read_data));
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;
  // Two-stage registered-output SRAM with new-data read-during-write.
  logic [DW-1:0] sram_mem [2**AW];
  logic [DW-1:0] rd0, rd1;
  always @(posedge i_clk) begin
    if (o_sram_write_enable) sram_mem[o_sram_address] <= o_sram_write_data;
    rd0 <= o_sram_write_enable ? o_sram_write_data : sram_mem[o_sram_address];
    rd1 <= rd0;
  end
  assign i_sram_read_data = rd1;
  int            checks = 0, errors = 0, n_acc = 0;
  bit            rand_rdy = 0, ready_en_exp = 0;
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Monitor: the queue size at this point equals the reads the DUT still owes.
  logic [DW-1:0] e;
  int            a;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      ready_en_exp = 0;
      check("reset_outputs", {o_req_ready, o_rsp_valid, o_busy, o_sram_write_enable}, 0);
    end else begin
      check("occupancy_bound", exp_q.size() <= DEPTH, 1);
      check("busy", o_busy, exp_q.size() != 0);
      check("req_ready", o_req_ready, ready_en_exp && exp_q.size() < DEPTH);
      ready_en_exp = 1;
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) check("spurious_rsp", o_rsp_valid, 0);
        else if (i_rsp_ready) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rsp_data", o_rsp_data, e);
          check("rsp_latency_min", (cyc - a) >= RL + 1, 1);
        end
      end
    end
  end
  task automatic sample_accept(output bit acc);
    @(negedge i_clk);
    #1;
    acc = i_rst_n && i_req_valid && o_req_ready;
    if (i_rst_n) check("sram_we", o_sram_write_enable, acc && i_req_write);
    if (acc) begin
      n_acc++;
      check("sram_addr", o_sram_address, i_req_address);
      if (i_req_write) begin
        check("sram_wdata", o_sram_write_data, i_req_data);
        ref_mem[i_req_address] = i_req_data;
      end else begin
        exp_q.push_back(ref_mem[i_req_address]);
        acc_q.push_back(cyc);
      end
    end
  endtask
  task automatic issue(input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bit acc;
    int t = 0;
    @(posedge i_clk);
    #1;
    i_req_valid = 1; i_req_write = w; i_req_address = ad; i_req_data = d;
    if (rand_rdy) i_rsp_ready = 1'($urandom_range(0, 1));
    sample_accept(acc);
    while (!acc) begin
      if (++t > 100) begin
        check("issue_timeout", 1, 0);
        i_req_valid = 0;
        return;
      end
      @(posedge i_clk);
      #1;
      if (rand_rdy) i_rsp_ready = 1'($urandom_range(0, 1));
      sample_accept(acc);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      i_req_valid = 0;
      if (rand_rdy) i_rsp_ready = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic drain();
    int t = 0;
    rand_rdy = 0;
    idle(1);
    i_rsp_ready = 1;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    check("drain_timeout", exp_q.size() == 0, 1);
    idle(2);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit            acc, have;
    int            first, base, lat;
    logic [DW-1:0] cap;
    // Reset held with a pending write request
    i_req_valid = 1; i_req_write = 1; i_req_address = 5; i_req_data = '1;
    repeat (5) begin
      @(negedge i_clk);
      #1;
      check("rst_ready", o_req_ready, 0);
      check("rst_we", o_sram_write_enable, 0);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1;
    @(negedge i_clk);
    #1;
    check("ready_release_cycle", o_req_ready, 0);
    @(posedge i_clk);
    #1;
    i_req_valid = 0;
    @(negedge i_clk);
    #1;
    check("ready_after_release", o_req_ready, 1);
    // Preload lines 0..15 with data = address, then stream 16 reads
    for (int i = 0; i < 16; i++) issue(1, AW'(i), DW'(i));
    issue(0, 0, 0);
    first = cyc;
    for (int i = 1; i < 16; i++) issue(0, AW'(i), 0);
    check("b2b_no_stall", cyc - first, 15);
    drain();
    // Write then read the same line on the next cycle
    issue(1, 3, {16{8'hA5}});
    issue(0, 3, 0);
    base = cyc;
    idle(1);
    lat = -1;
    for (int t = 0; t < 10 && lat < 0; t++) begin
      @(negedge i_clk);
      if (o_rsp_valid) lat = cyc - base;
    end
    check("raw_latency", lat, RL + 1);
    check("raw_data", o_rsp_data, {16{8'hA5}});
    drain();
    // Full backpressure
    i_rsp_ready = 0;
    base = n_acc;
    have = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      i_req_valid = 1; i_req_write = 0; i_req_address = AW'(i + 4);
      sample_accept(acc);
      if (o_rsp_valid && !have) begin
        cap = o_rsp_data;
        have = 1;
      end else if (have) check("rsp_stable", o_rsp_data, cap);
    end
    check("bp_accepted", n_acc - base, DEPTH);
    check("bp_ready_low", o_req_ready, 0);
    drain();
    @(negedge i_clk);
    #1;
    check("bp_resume", o_req_ready, 1);
    // Reset with two reads in flight and one buffered
    i_rsp_ready = 0;
    issue(0, 1, 0);
    issue(0, 2, 0);
    issue(0, 7, 0);
    idle(1);
    @(negedge i_clk);
    check("midflight_buffered", o_rsp_valid, 1);
    #1;
    i_rst_n = 0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midflight_rsp_valid", o_rsp_valid, 0);
    check("midflight_busy", o_busy, 0);
    i_rsp_ready = 1;
    idle(2);
    i_rst_n = 1;
    idle(10);
    check("midflight_no_stale", o_busy, 0);
    // Random traffic with random backpressure over many FIFO wraps
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 9) < 3), AW'($urandom_range(0, 15)),
            {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_line_port_ctrl.md
# sram_line_port_ctrl

Request/response front-end for the single-port line SRAM wrapper. It accepts read and write line requests on a valid/ready interface and drives the SRAM port. It tracks the SRAM's fixed read latency and buffers returned lines in a small response FIFO, so that downstream backpressure never loses data. It sits directly upstream of the line SRAM, between it and the cache/line-fill logic.

## Interface
Parameters:
- DATA_WIDTH, 128: line width; must match the SRAM wrapper.
- ADDRESS_WIDTH, 7: line address width; must match the SRAM wrapper.
- READ_LATENCY, 2: SRAM read latency in cycles. Legal values: 2 (registered output) or 1 (unregistered output).
- RSP_DEPTH, 4: response FIFO depth in lines. Must be ≥ READ_LATENCY+2; this bound guarantees full throughput.

Ports:
- i_clk, input, 1: the single clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_req_valid, input, 1: request valid.
- o_req_ready, output, 1: request accepted when i_req_valid && o_req_ready.
- i_req_write, input, 1: 1 = write, 0 = read.
- i_req_address, input, ADDRESS_WIDTH: line address.
- i_req_data, input, DATA_WIDTH: write line data.
- o_rsp_valid, output, 1: read response valid.
- i_rsp_ready, input, 1: response consumed when o_rsp_valid && i_rsp_ready.
- o_rsp_data, output, DATA_WIDTH: read line data.
- o_busy, output, 1: reads in flight or FIFO non-empty.
- o_sram_address, output, ADDRESS_WIDTH: to SRAM i_address.
- o_sram_write_data, output, DATA_WIDTH: to SRAM i_write_data.
- o_sram_write_enable, output, 1: to SRAM i_write_enable.
- i_sram_read_data, input, DATA_WIDTH: from SRAM o_read_data.

## Operation
- **SRAM drive.** The SRAM-side outputs are combinational pass-throughs:
  - o_sram_address = i_req_address.
  - o_sram_write_data = i_req_data.
  - o_sram_write_enable = i_req_valid && o_req_ready && i_req_write.
- **In-flight tracking.** A READ_LATENCY-bit shift register (pipe) shifts in 1 on each accepted read and 0 otherwise. When the oldest bit is 1, i_sram_read_data is pushed into the response FIFO at that edge.
- **Credits.** occupancy = FIFO count + popcount(pipe).
  - o_req_ready = ready_en && (occupancy < RSP_DEPTH).
  - ready_en is a flop: cleared by reset, set on the first clock after reset release.
  - The same credit gate applies to writes; writes do not consume credit.
- **Occupancy bound.** Because reads are admitted only with credit, the FIFO never overflows. A push with the FIFO full is a design error; assert on it in simulation.
- **Response FIFO.**
  - RSP_DEPTH entries, circular read/write pointers that wrap modulo RSP_DEPTH, count of width clog2(RSP_DEPTH+1).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - o_rsp_valid = (count != 0); o_rsp_data = entry at the read pointer, stable while o_rsp_valid && !i_rsp_ready.
- **Ordering.** Responses return strictly in request order.
- **Read-after-write.** A read to the address written in the previous cycle returns the new data; this relies on the SRAM's new-data read-during-write mode, with no local forwarding. A read in the same cycle as a write is impossible (one request per cycle).
- **o_busy** = |pipe || (count != 0).
- **Reset** (asynchronous assert, synchronous-safe deassert by design):
  - pipe, pointers, count and ready_en clear to 0.
  - Outputs during and after reset: o_req_ready=0, o_rsp_valid=0, o_busy=0, o_sram_write_enable=0.
  - FIFO data storage is not reset.
- **Reset mid-operation.** In-flight reads and buffered responses are discarded; no response for them ever appears.

## Timing
- A read accepted in cycle N:
  - READ_LATENCY=2: data sampled from the SRAM at the end of cycle N+2; o_rsp_valid is high in cycle N+3.
  - READ_LATENCY=1: o_rsp_valid is high in cycle N+2.
- Read latency from acceptance to response = READ_LATENCY+1 cycles.
- A write accepted in cycle N is written at the end of cycle N; a read accepted in N+1 sees the new data.
- **Throughput.** With i_rsp_ready held high, one request per cycle is sustained indefinitely.
- **Backpressure.** With i_rsp_ready held low, at most RSP_DEPTH reads are accepted. o_req_ready drops in the cycle occupancy reaches RSP_DEPTH. It rises in the cycle after the pop that frees a slot (occupancy is registered state).
- o_req_ready depends only on registered state. It never depends combinationally on i_req_valid, i_req_write or i_rsp_ready.

## Test plan
1. **Reset.** Hold i_rst_n low 5 cycles with i_req_valid=1 -> o_req_ready=0 and o_sram_write_enable=0 throughout; o_req_ready=1 from the 2nd cycle after release.
2. **Write then read, no stall.** Write 0xA5…A5 to addr 3, read addr 3 next cycle -> o_rsp_valid exactly 3 cycles after read acceptance with data 0xA5…A5.
3. **Back-to-back reads.** 16 consecutive reads of addrs 0–15 with preloaded data = address, i_rsp_ready=1 -> o_req_ready never drops; 16 responses in order with data 0–15.
4. **Full backpressure.** i_rsp_ready=0, continuous reads -> exactly 4 accepted, o_req_ready=0 afterwards, o_rsp_data stable. Release i_rsp_ready -> 4 in-order responses, then acceptance resumes.
5. **Reset mid-flight.** 2 reads in flight and 1 buffered, assert i_rst_n -> o_rsp_valid=0 and o_busy=0 immediately; no stale response after release.
6. **Simultaneous push/pop at FIFO wrap.** Drive random i_rsp_ready over ≥3 pointer wraps -> scoreboard confirms no loss, no duplication, in-order data, and occupancy ≤ 4.
